// File: rtl/data_mem_responder.sv
// Data-memory responder: word-addressed RAM, LED register and a byte TX FIFO
// drained over a valid/ready stream, with registered one-cycle reads.
module data_mem_responder #(
    parameter int          DEPTH      = 256,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [31:0] LED_ADDR   = 32'hFFFF_FFF0,
    parameter logic [31:0] TX_ADDR    = 32'hFFFF_FFF1,
    parameter logic [31:0] STAT_ADDR  = 32'hFFFF_FFF2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_data,
    input  logic        mem_we,
    output logic [31:0] rd_data,
    output logic [7:0]  leds,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        overflow
);

    localparam int          AW         = $clog2(DEPTH);
    localparam int          PW         = $clog2(FIFO_DEPTH);
    localparam logic [31:0] RAM_LIMIT  = 32'(DEPTH);
    localparam logic [PW:0] FULL_COUNT = (PW+1)'(FIFO_DEPTH);

    logic [31:0]   ram      [DEPTH];
    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;

    logic        ram_hit;
    logic        led_hit;
    logic        tx_hit;
    logic        stat_hit;
    logic        full;
    logic        empty;
    logic        pop;
    logic        push_req;
    logic        push;
    logic [31:0] rd_next;

    assign ram_hit  = (mem_addr < RAM_LIMIT);
    assign led_hit  = (mem_addr == LED_ADDR);
    assign tx_hit   = (mem_addr == TX_ADDR);
    assign stat_hit = (mem_addr == STAT_ADDR);

    assign full     = (count == FULL_COUNT);
    assign empty    = (count == '0);
    assign tx_valid = !empty;
    assign tx_data  = fifo_mem[rd_ptr];

    // A push into a full FIFO is still accepted when the same edge pops a byte.
    assign pop      = tx_valid && tx_ready;
    assign push_req = mem_we && tx_hit;
    assign push     = push_req && (!full || pop);

    always_comb begin
        rd_next = '0;
        if (ram_hit) begin
            rd_next = ram[mem_addr[AW-1:0]];
        end else if (led_hit) begin
            rd_next = {24'b0, leds};
        end else if (stat_hit) begin
            rd_next = {29'b0, overflow, full, empty};
        end
    end

    // Storage arrays carry no reset; only the pointers define FIFO contents.
    always_ff @(posedge clk) begin
        if (mem_we && ram_hit) begin
            ram[mem_addr[AW-1:0]] <= mem_data;
        end
        if (push) begin
            fifo_mem[wr_ptr] <= mem_data[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data  <= '0;
            leds     <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            rd_data <= rd_next;
            if (mem_we && led_hit) begin
                leds <= mem_data[7:0];
            end
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                count <= count + (PW+1)'(1);
            end else if (pop && !push) begin
                count <= count - (PW+1)'(1);
            end
            if (mem_we && stat_hit) begin
                overflow <= 1'b0;
            end else if (push_req && !push) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: read and TX byte scoreboards
// fed at stimulus time and drained when the DUT produces data.
module tb_data_mem_responder;

    localparam logic [31:0] LED_ADDR  = 32'hFFFF_FFF0;
    localparam logic [31:0] TX_ADDR   = 32'hFFFF_FFF1;
    localparam logic [31:0] STAT_ADDR = 32'hFFFF_FFF2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic        mem_we;
    logic [31:0] rd_data;
    logic [7:0]  leds;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        overflow;

    int checks   = 0;
    int failures = 0;

    logic [31:0] rd_q[$];
    logic [7:0]  tx_q[$];

    data_mem_responder dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .mem_we   (mem_we),
        .rd_data  (rd_data),
        .leds     (leds),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        mem_addr = addr;
        mem_data = data;
        mem_we   = 1'b1;
        step();
        mem_we   = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] got;
        rst_n = 1'b0;
        step();
        step();
        got = {rd_data[31:0]};
        checks++;
        if (got !== 32'h0) begin failures++; $display("FAIL reset_rd_data got=%h exp=0", got); end
        checks++;
        if ({leds, tx_valid, overflow} !== 10'b0) begin
            failures++;
            $display("FAIL reset_outputs got leds=%h tx_valid=%b overflow=%b exp all 0", leds, tx_valid, overflow);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_ram_write_read();
        logic [31:0] exp;
        wr(32'd5, 32'hDEAD_BEEF);
        mem_addr = 32'd5;
        rd_q.push_back(32'hDEAD_BEEF);
        step();
        exp = rd_q.pop_front();
        checks++;
        if (rd_data !== exp) begin failures++; $display("FAIL ram_read got=%h exp=%h", rd_data, exp); end
    endtask

    task automatic test_collision();
        logic [31:0] exp;
        wr(32'd3, 32'd1);
        mem_addr = 32'd3;
        mem_data = 32'd2;
        mem_we   = 1'b1;
        rd_q.push_back(32'd1);
        step();
        mem_we = 1'b0;
        exp = rd_q.pop_front();
        checks++;
        if (rd_data !== exp) begin failures++; $display("FAIL read_first got=%h exp=%h", rd_data, exp); end
        rd_q.push_back(32'd2);
        step();
        exp = rd_q.pop_front();
        checks++;
        if (rd_data !== exp) begin failures++; $display("FAIL reread_after_write got=%h exp=%h", rd_data, exp); end
    endtask

    task automatic test_led_oob();
        logic [31:0] exp;
        wr(32'd0, 32'h1234_5678);
        wr(LED_ADDR, 32'h0000_01A5);
        checks++;
        if (leds !== 8'hA5) begin failures++; $display("FAIL led_write got=%h exp=a5", leds); end
        mem_addr = LED_ADDR;
        rd_q.push_back(32'h0000_00A5);
        step();
        exp = rd_q.pop_front();
        checks++;
        if (rd_data !== exp) begin failures++; $display("FAIL led_read got=%h exp=%h", rd_data, exp); end
        wr(32'd256, 32'hCAFE_F00D);
        mem_addr = 32'd256;
        rd_q.push_back(32'h0);
        step();
        exp = rd_q.pop_front();
        checks++;
        if (rd_data !== exp) begin failures++; $display("FAIL oob_read got=%h exp=%h", rd_data, exp); end
        mem_addr = 32'd0;
        rd_q.push_back(32'h1234_5678);
        step();
        exp = rd_q.pop_front();
        checks++;
        if (rd_data !== exp) begin failures++; $display("FAIL oob_no_alias got=%h exp=%h", rd_data, exp); end
    endtask

    task automatic test_overflow();
        logic [31:0] exp;
        int model_count = 0;
        logic exp_ovf = 1'b0;
        tx_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (model_count < 8) begin
                tx_q.push_back(8'(8'h10 + i));
                model_count++;
            end else begin
                exp_ovf = 1'b1;
            end
            wr(TX_ADDR, 32'h0000_0010 + 32'(i));
        end
        checks++;
        if (overflow !== exp_ovf) begin failures++; $display("FAIL overflow_set got=%b exp=%b", overflow, exp_ovf); end
        mem_addr = STAT_ADDR;
        rd_q.push_back(32'h6);
        step();
        exp = rd_q.pop_front();
        checks++;
        if (rd_data !== exp) begin failures++; $display("FAIL stat_full_ovf got=%h exp=%h", rd_data, exp); end
        mem_addr = TX_ADDR;
        rd_q.push_back(32'h0);
        step();
        exp = rd_q.pop_front();
        checks++;
        if (rd_data !== exp) begin failures++; $display("FAIL tx_addr_read got=%h exp=%h", rd_data, exp); end
        mem_addr = 32'd0;
        tx_ready = 1'b1;
        for (int c = 0; c < 20 && tx_q.size() > 0; c++) begin
            if (tx_valid) begin
                checks++;
                if (tx_data !== tx_q[0]) begin failures++; $display("FAIL drain_order got=%h exp=%h", tx_data, tx_q[0]); end
                void'(tx_q.pop_front());
            end
            step();
        end
        checks++;
        if (tx_q.size() != 0) begin failures++; $display("FAIL drain_timeout got=%0d left exp=0", tx_q.size()); tx_q.delete(); end
        checks++;
        if (tx_valid !== 1'b0) begin failures++; $display("FAIL drain_valid_low got=%b exp=0", tx_valid); end
        tx_ready = 1'b0;
        wr(STAT_ADDR, 32'h0);
        checks++;
        if (overflow !== 1'b0) begin failures++; $display("FAIL overflow_clear got=%b exp=0", overflow); end
        mem_addr = STAT_ADDR;
        rd_q.push_back(32'h1);
        step();
        exp = rd_q.pop_front();
        checks++;
        if (rd_data !== exp) begin failures++; $display("FAIL stat_empty got=%h exp=%h", rd_data, exp); end
    endtask

    task automatic test_full_push_pop();
        logic [31:0] exp;
        tx_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tx_q.push_back(8'(8'h20 + i));
            wr(TX_ADDR, 32'h0000_0020 + 32'(i));
        end
        mem_addr = TX_ADDR;
        mem_data = 32'h0000_0055;
        mem_we   = 1'b1;
        tx_ready = 1'b1;
        checks++;
        if (!tx_valid || tx_data !== tx_q[0]) begin
            failures++;
            $display("FAIL full_pop_head got valid=%b data=%h exp valid=1 data=%h", tx_valid, tx_data, tx_q[0]);
        end
        void'(tx_q.pop_front());
        tx_q.push_back(8'h55);
        step();
        mem_we   = 1'b0;
        tx_ready = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin failures++; $display("FAIL full_push_pop_ovf got=%b exp=0", overflow); end
        mem_addr = STAT_ADDR;
        rd_q.push_back(32'h2);
        step();
        exp = rd_q.pop_front();
        checks++;
        if (rd_data !== exp) begin failures++; $display("FAIL full_count_kept got=%h exp=%h", rd_data, exp); end
        mem_addr = 32'd0;
        tx_ready = 1'b1;
        for (int c = 0; c < 20 && tx_q.size() > 0; c++) begin
            if (tx_valid) begin
                checks++;
                if (tx_data !== tx_q[0]) begin failures++; $display("FAIL full_drain_order got=%h exp=%h", tx_data, tx_q[0]); end
                void'(tx_q.pop_front());
            end
            step();
        end
        checks++;
        if (tx_q.size() != 0) begin failures++; $display("FAIL full_drain_timeout got=%0d left exp=0", tx_q.size()); tx_q.delete(); end
        checks++;
        if (tx_valid !== 1'b0) begin failures++; $display("FAIL full_drain_valid_low got=%b exp=0", tx_valid); end
        tx_ready = 1'b0;
    endtask

    task automatic test_reset_midstream();
        logic [31:0] exp;
        tx_ready = 1'b0;
        wr(LED_ADDR, 32'h0000_00FF);
        for (int i = 0; i < 3; i++) begin
            wr(TX_ADDR, 32'h0000_0030 + 32'(i));
        end
        mem_addr = LED_ADDR;
        rd_q.push_back(32'h0000_00FF);
        step();
        exp = rd_q.pop_front();
        checks++;
        if (rd_data !== exp || tx_valid !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset_state got rd=%h valid=%b exp rd=%h valid=1", rd_data, tx_valid, exp);
        end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        checks++;
        if ({tx_valid, leds, rd_data, overflow} !== 42'b0) begin
            failures++;
            $display("FAIL midstream_reset got valid=%b leds=%h rd=%h ovf=%b exp all 0", tx_valid, leds, rd_data, overflow);
        end
        mem_addr = 32'd0;
        tx_ready = 1'b1;
        step();
        step();
        checks++;
        if (tx_valid !== 1'b0) begin failures++; $display("FAIL post_reset_empty got=%b exp=0", tx_valid); end
        tx_ready = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        mem_addr = '0;
        mem_data = '0;
        mem_we   = 1'b0;
        tx_ready = 1'b0;
        test_reset();
        test_ram_write_read();
        test_collision();
        test_led_oob();
        test_overflow();
        test_full_push_pop();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
